// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: fixed-priority pipeline writeback plus round-robin
// long-latency sources, one output register stage, and a busy scoreboard for in-flight results.
module rf_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [5*NREQ-1:0] req_rd,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              rsv_valid,
  input  logic [4:0]        rsv_rd,
  output logic [31:0]       busy,
  output logic [4:0]        rf_rd,
  output logic              rf_reg_write,
  output logic [31:0]       rf_wdata
);

  localparam int IDXW  = $clog2(NREQ);
  localparam int NSLOT = 1 << IDXW;

  // Requester fields unpacked into arrays padded to a power of two so the selected
  // index can never address past the end.
  logic [4:0]  rd_arr   [NSLOT];
  logic [31:0] data_arr [NSLOT];

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NREQ) begin : g_used
        assign rd_arr[gi]   = req_rd[5*gi +: 5];
        assign data_arr[gi] = req_data[32*gi +: 32];
      end else begin : g_pad
        assign rd_arr[gi]   = 5'd0;
        assign data_arr[gi] = 32'd0;
      end
    end
  endgenerate

  logic [IDXW-1:0] rr_reg, rr_next;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_any;
  logic            xfer_lr;
  logic [4:0]      sel_rd;
  logic [31:0]     sel_data;

  logic [4:0]      rf_rd_reg, rf_rd_next;
  logic            rf_reg_write_reg, rf_reg_write_next;
  logic [31:0]     rf_wdata_reg, rf_wdata_next;
  logic [31:1]     busy_reg, busy_next;

  // Requester 0 wins outright; otherwise scan rr..NREQ-1 then 1..rr-1.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (req_valid[0]) begin
      gnt_any = 1'b1;
    end else begin
      for (int i = 1; i < NREQ; i++) begin
        if (!gnt_any && req_valid[i] && (i >= int'(rr_reg))) begin
          gnt_any = 1'b1;
          gnt_idx = IDXW'(i);
        end
      end
      for (int i = 1; i < NREQ; i++) begin
        if (!gnt_any && req_valid[i] && (i < int'(rr_reg))) begin
          gnt_any = 1'b1;
          gnt_idx = IDXW'(i);
        end
      end
    end
  end

  assign req_ready = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  assign xfer_lr   = gnt_any && (gnt_idx != '0);
  assign sel_rd    = rd_arr[gnt_idx];
  assign sel_data  = data_arr[gnt_idx];

  always_comb begin
    rr_next           = rr_reg;
    rf_rd_next        = rf_rd_reg;
    rf_wdata_next     = rf_wdata_reg;
    rf_reg_write_next = 1'b0;
    if (gnt_any) begin
      rf_rd_next        = sel_rd;
      rf_wdata_next     = sel_data;
      rf_reg_write_next = (sel_rd != 5'd0);
    end
    if (xfer_lr) begin
      rr_next = (gnt_idx == IDXW'(NREQ - 1)) ? IDXW'(1) : gnt_idx + 1'b1;
    end
  end

  // A new reservation beats a retiring write to the same register.
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (rsv_valid && (rsv_rd == 5'(gi))) ||
                             (busy_reg[gi] && !(xfer_lr && (sel_rd == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_reg           <= IDXW'(1);
      rf_rd_reg        <= 5'd0;
      rf_reg_write_reg <= 1'b0;
      rf_wdata_reg     <= 32'd0;
      busy_reg         <= '0;
    end else begin
      rr_reg           <= rr_next;
      rf_rd_reg        <= rf_rd_next;
      rf_reg_write_reg <= rf_reg_write_next;
      rf_wdata_reg     <= rf_wdata_next;
      busy_reg         <= busy_next;
    end
  end

  assign rf_rd        = rf_rd_reg;
  assign rf_reg_write = rf_reg_write_reg;
  assign rf_wdata     = rf_wdata_reg;
  assign busy         = {busy_reg, 1'b0};

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (NREQ=3): priority, round-robin, scoreboard, x0 and reset.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [31:0] D1 = 32'h2222_2222;
  localparam logic [31:0] D2 = 32'h3333_3333;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_rd;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsv_valid;
  logic [4:0]        rsv_rd;
  logic [31:0]       busy;
  logic [4:0]        rf_rd;
  logic              rf_reg_write;
  logic [31:0]       rf_wdata;

  int tests = 0;
  int fails = 0;

  rf_wb_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsv_valid    (rsv_valid),
    .rsv_rd       (rsv_rd),
    .busy         (busy),
    .rf_rd        (rf_rd),
    .rf_reg_write (rf_reg_write),
    .rf_wdata     (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_rd(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    req_rd = {r2, r1, r0};
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    req_data  = {D2, D1, D0};
    rsv_valid = 1'b0;
    rsv_rd    = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_we", 32'(rf_reg_write), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // requester 0 has fixed priority
    req_valid = 3'b111;
    set_rd(5'd5, 5'd6, 5'd7);
    settle();
    chk("prio_ready", 32'(req_ready), 32'b001);
    tick();
    chk("prio_rf_rd", 32'(rf_rd), 32'd5);
    chk("prio_we", 32'(rf_reg_write), 32'd1);
    chk("prio_wdata", rf_wdata, D0);

    // round-robin alternation; rr still 1 after the requester-0 win
    req_valid = 3'b110;
    settle();
    chk("rr_ready_a", 32'(req_ready), 32'b010);
    tick();
    chk("rr_rd_6a", 32'(rf_rd), 32'd6);
    chk("rr_we_a", 32'(rf_reg_write), 32'd1);
    chk("rr_wdata_a", rf_wdata, D1);
    chk("rr_ready_b", 32'(req_ready), 32'b100);
    tick();
    chk("rr_rd_7a", 32'(rf_rd), 32'd7);
    chk("rr_we_b", 32'(rf_reg_write), 32'd1);
    chk("rr_ready_c", 32'(req_ready), 32'b010);
    tick();
    chk("rr_rd_6b", 32'(rf_rd), 32'd6);
    chk("rr_ready_d", 32'(req_ready), 32'b100);
    tick();
    chk("rr_rd_7b", 32'(rf_rd), 32'd7);
    chk("rr_wdata_b", rf_wdata, D2);

    // idle: write enable drops, rd/data hold
    req_valid = 3'b000;
    tick();
    chk("idle_we", 32'(rf_reg_write), 32'd0);
    chk("idle_rf_rd", 32'(rf_rd), 32'd7);
    chk("idle_wdata", rf_wdata, D2);

    // scoreboard round trip
    rsv_valid = 1'b1;
    rsv_rd    = 5'd9;
    tick();
    rsv_valid = 1'b0;
    chk("sb_set", busy, 32'h0000_0200);
    req_valid = 3'b100;
    set_rd(5'd0, 5'd0, 5'd9);
    settle();
    chk("sb_ready", 32'(req_ready), 32'b100);
    tick();
    req_valid = 3'b000;
    chk("sb_clr_busy", busy, 32'd0);
    chk("sb_clr_rd", 32'(rf_rd), 32'd9);
    chk("sb_clr_we", 32'(rf_reg_write), 32'd1);

    // requester-0 write does not clear busy
    rsv_valid = 1'b1;
    rsv_rd    = 5'd9;
    tick();
    rsv_valid = 1'b0;
    req_valid = 3'b001;
    set_rd(5'd9, 5'd0, 5'd0);
    tick();
    chk("r0_keep_busy", busy, 32'h0000_0200);

    // same-register set and clear: set wins, write still issues
    req_valid = 3'b010;
    set_rd(5'd0, 5'd9, 5'd0);
    rsv_valid = 1'b1;
    rsv_rd    = 5'd9;
    settle();
    chk("sc_ready", 32'(req_ready), 32'b010);
    tick();
    chk("sc_busy", busy, 32'h0000_0200);
    chk("sc_rf_rd", 32'(rf_rd), 32'd9);
    chk("sc_we", 32'(rf_reg_write), 32'd1);

    // different registers: set 12, clear 9 (rr=2 now)
    req_valid = 3'b100;
    set_rd(5'd0, 5'd0, 5'd9);
    rsv_rd    = 5'd12;
    tick();
    rsv_valid = 1'b0;
    chk("sc_diff_busy", busy, 32'h0000_1000);

    // x0 write: accepted, no write enable (rr back to 1)
    req_valid = 3'b010;
    set_rd(5'd0, 5'd0, 5'd0);
    req_data  = {D2, 32'hDEAD_BEEF, D0};
    settle();
    chk("x0_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = 3'b000;
    chk("x0_we", 32'(rf_reg_write), 32'd0);
    chk("x0_rf_rd", 32'(rf_rd), 32'd0);
    chk("x0_wdata", rf_wdata, 32'hDEAD_BEEF);

    // x0 reservation ignored
    rsv_valid = 1'b1;
    rsv_rd    = 5'd0;
    tick();
    rsv_valid = 1'b0;
    chk("x0_rsv_busy", busy, 32'h0000_1000);

    // async reset mid-transfer (rr=2 beforehand)
    req_valid = 3'b010;
    set_rd(5'd0, 5'd3, 5'd4);
    req_data  = {D2, D1, D0};
    tick();
    chk("pre_rst_rd", 32'(rf_rd), 32'd3);
    req_valid = 3'b110;
    settle();
    chk("pre_rst_ready", 32'(req_ready), 32'b100);
    #1 rst = 1'b1;
    #1;
    chk("arst_rf_rd", 32'(rf_rd), 32'd0);
    chk("arst_we", 32'(rf_reg_write), 32'd0);
    chk("arst_wdata", rf_wdata, 32'd0);
    chk("arst_busy", busy, 32'd0);
    chk("arst_ready", 32'(req_ready), 32'b010);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_rd", 32'(rf_rd), 32'd3);
    chk("post_rst_we", 32'(rf_reg_write), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
